// File: rtl/iobus_sched_if.sv
// Bundles the fast-side CPU handshake and the slow I/O bus pins of iobus_sched.
// The slave modport is the scheduler's view; master is the CPU/slow-device side.
interface iobus_sched_if #(
    parameter int AW = 23,
    parameter int DW = 16
);
    logic          BACT;
    logic          IOCS;
    logic          IOPWCS;
    logic          RnW;
    logic [AW-1:0] A;
    logic [DW-1:0] DI;
    logic [1:0]    DS;
    logic          IOPWReady;
    logic          IONPReady;
    logic [DW-1:0] DO;
    logic          C8Mr;
    logic          IOREQ;
    logic [AW-1:0] IOA;
    logic [DW-1:0] IOD;
    logic          IORnW;
    logic [1:0]    IODS;
    logic          IOACK;
    logic [DW-1:0] IODI;
    logic          IOERR;

    modport master (
        output BACT, IOCS, IOPWCS, RnW, A, DI, DS, C8Mr, IOACK, IODI,
        input  IOPWReady, IONPReady, DO, IOREQ, IOA, IOD, IORnW, IODS, IOERR
    );

    modport slave (
        input  BACT, IOCS, IOPWCS, RnW, A, DI, DS, C8Mr, IOACK, IODI,
        output IOPWReady, IONPReady, DO, IOREQ, IOA, IOD, IORnW, IODS, IOERR
    );
endinterface

// File: rtl/iobus_sched.sv
// Slow I/O bus scheduler: posts writes into a small FIFO, drains them in order,
// then runs non-posted accesses, with a strobe-counted watchdog on every slow cycle.
module iobus_sched #(
    parameter int DEPTH = 2,
    parameter int AW    = 23,
    parameter int DW    = 16,
    parameter int TMO   = 255
) (
    input  logic         FCLK,
    input  logic         nRES,
    iobus_sched_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_END  = 2'd2;

    logic [AW-1:0] r_fifoA [DEPTH];
    logic [DW-1:0] r_fifoD [DEPTH];
    logic [1:0]    r_fifoS [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic [1:0]    r_state;
    logic          r_srcFifo;
    logic [7:0]    r_wdog;
    logic          r_ioReq;
    logic [AW-1:0] r_ioA;
    logic [DW-1:0] r_ioD;
    logic          r_ioRnW;
    logic [1:0]    r_ioDS;
    logic          r_ioErr;

    logic          r_taken;
    logic          r_pwReady;
    logic          r_npReady;
    logic [DW-1:0] r_do;

    logic w_empty;
    logic w_full;
    logic w_waitStrobe;
    logic w_tmoHit;
    logic w_cycEnd;
    logic w_pop;
    logic w_npDone;
    logic w_pwReq;
    logic w_push;
    logic w_npPend;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_waitStrobe = (r_state == S_WAIT) && bus.C8Mr;
    assign w_tmoHit     = w_waitStrobe && !bus.IOACK && (r_wdog == 8'(TMO - 1));
    assign w_cycEnd     = (w_waitStrobe && bus.IOACK) || w_tmoHit;
    assign w_pop        = w_cycEnd && r_srcFifo;
    assign w_npDone     = w_cycEnd && !r_srcFifo;

    // A full FIFO may still accept a push on the edge that frees the head entry.
    assign w_pwReq  = bus.BACT && bus.IOCS && bus.IOPWCS && !bus.RnW && !r_taken;
    assign w_push   = w_pwReq && (!w_full || w_pop);
    assign w_npPend = bus.BACT && bus.IOCS && !(bus.IOPWCS && !bus.RnW) && !r_taken
                      && w_empty && (r_state == S_IDLE);

    always_ff @(posedge FCLK) begin
        if (w_push) begin
            r_fifoA[r_wrPtr] <= bus.A;
            r_fifoD[r_wrPtr] <= bus.DI;
            r_fifoS[r_wrPtr] <= bus.DS;
        end
    end

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Readies and the taken flag live for the rest of the fast cycle.
    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            r_taken   <= 1'b0;
            r_pwReady <= 1'b0;
            r_npReady <= 1'b0;
            r_do      <= '0;
        end else begin
            if (!bus.BACT) begin
                r_taken   <= 1'b0;
                r_pwReady <= 1'b0;
                r_npReady <= 1'b0;
            end else begin
                if (w_push || w_npDone) r_taken <= 1'b1;
                if (w_push)             r_pwReady <= 1'b1;
                if (w_npDone)           r_npReady <= 1'b1;
            end
            if (w_npDone && r_ioRnW) r_do <= w_tmoHit ? '1 : bus.IODI;
        end
    end

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            r_state   <= S_IDLE;
            r_srcFifo <= 1'b0;
            r_wdog    <= '0;
            r_ioReq   <= 1'b0;
            r_ioA     <= '0;
            r_ioD     <= '0;
            r_ioRnW   <= 1'b1;
            r_ioDS    <= '0;
            r_ioErr   <= 1'b0;
        end else begin
            r_ioErr <= 1'b0;
            if (bus.C8Mr) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_empty) begin
                            r_ioA     <= r_fifoA[r_rdPtr];
                            r_ioD     <= r_fifoD[r_rdPtr];
                            r_ioDS    <= r_fifoS[r_rdPtr];
                            r_ioRnW   <= 1'b0;
                            r_srcFifo <= 1'b1;
                            r_ioReq   <= 1'b1;
                            r_wdog    <= '0;
                            r_state   <= S_WAIT;
                        end else if (w_npPend) begin
                            r_ioA     <= bus.A;
                            r_ioD     <= bus.DI;
                            r_ioDS    <= bus.DS;
                            r_ioRnW   <= bus.RnW;
                            r_srcFifo <= 1'b0;
                            r_ioReq   <= 1'b1;
                            r_wdog    <= '0;
                            r_state   <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.IOACK) begin
                            r_ioReq <= 1'b0;
                            r_state <= S_END;
                        end else begin
                            r_wdog <= r_wdog + 8'd1;
                            if (w_tmoHit) begin
                                r_ioErr <= 1'b1;
                                r_ioReq <= 1'b0;
                                r_state <= S_END;
                            end
                        end
                    end
                    S_END:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.IOPWReady = r_pwReady;
    assign bus.IONPReady = r_npReady;
    assign bus.DO        = r_do;
    assign bus.IOREQ     = r_ioReq;
    assign bus.IOA       = r_ioA;
    assign bus.IOD       = r_ioD;
    assign bus.IORnW     = r_ioRnW;
    assign bus.IODS      = r_ioDS;
    assign bus.IOERR     = r_ioErr;
endmodule

// File: tb/tb_iobus_sched.sv
// Scoreboard bench for iobus_sched: expected slow-bus cycles and read results are
// queued when a fast cycle is driven and compared when the DUT produces them.
module tb_iobus_sched;
    localparam int AW    = 23;
    localparam int DW    = 16;
    localparam int DEPTH = 2;
    localparam int TMO   = 255;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    ds;
        logic          rnw;
    } busTxn_t;

    logic FCLK = 1'b0;
    logic nRES = 1'b0;

    iobus_sched_if #(.AW(AW), .DW(DW)) bus ();

    iobus_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .FCLK (FCLK),
        .nRES (nRES),
        .bus  (bus)
    );

    always #5 FCLK = ~FCLK;

    busTxn_t       expQ [$];
    logic [DW-1:0] rdQ  [$];
    int            compared   = 0;
    int            mismatched = 0;
    int            errCount   = 0;
    bit            ackEn      = 1'b0;
    int            ackDelay   = 2;
    logic [DW-1:0] rdData     = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slow-side device model: strobe every other FCLK, ack after ackDelay strobes.
    initial begin
        int phase;
        int waitCnt;
        phase        = 0;
        waitCnt      = 0;
        bus.C8Mr     = 1'b0;
        bus.IOACK    = 1'b0;
        bus.IODI     = '0;
        forever begin
            @(negedge FCLK);
            if (bus.IOREQ) begin
                if (bus.C8Mr) waitCnt++;
            end else begin
                waitCnt = 0;
            end
            bus.IOACK = bus.IOREQ && ackEn && (waitCnt >= ackDelay);
            bus.IODI  = rdData;
            phase++;
            bus.C8Mr  = phase[0];
        end
    end

    // Monitor: every new slow cycle is matched against the head of the scoreboard.
    initial begin
        logic    prevReq;
        busTxn_t e;
        prevReq = 1'b0;
        forever begin
            @(negedge FCLK);
            if (bus.IOERR === 1'b1) errCount++;
            if (bus.IOREQ === 1'b1 && !prevReq) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedCycle", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("IOA", 32'(bus.IOA), 32'(e.a));
                    checkOutput("IORnW", 32'(bus.IORnW), 32'(e.rnw));
                    checkOutput("IODS", 32'(bus.IODS), 32'(e.ds));
                    if (!e.rnw) checkOutput("IOD", 32'(bus.IOD), 32'(e.d));
                end
            end
            prevReq = (bus.IOREQ === 1'b1);
        end
    end

    task automatic applyStimulus(input logic rnw, input logic pwcs, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [1:0] ds);
        busTxn_t t;
        @(negedge FCLK);
        bus.BACT   = 1'b1;
        bus.IOCS   = 1'b1;
        bus.IOPWCS = pwcs;
        bus.RnW    = rnw;
        bus.A      = a;
        bus.DI     = d;
        bus.DS     = ds;
        t.a   = a;
        t.d   = d;
        t.ds  = ds;
        t.rnw = rnw;
        expQ.push_back(t);
    endtask

    task automatic endCycle();
        @(negedge FCLK);
        bus.BACT = 1'b0;
        bus.IOCS = 1'b0;
    endtask

    task automatic afterEdge();
        @(posedge FCLK);
        #1;
    endtask

    task automatic waitReady(input bit np, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            afterEdge();
            if ((np ? bus.IONPReady : bus.IOPWReady) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drainBus(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge FCLK);
            if (expQ.size() == 0 && bus.IOREQ === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        repeat (8) @(negedge FCLK);
        checkOutput(tag, 32'(done), 32'd1);
        checkOutput({tag, "_IOREQ"}, 32'(bus.IOREQ), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_IOPWReady"}, 32'(bus.IOPWReady), 32'd0);
        checkOutput({tag, "_IONPReady"}, 32'(bus.IONPReady), 32'd0);
        checkOutput({tag, "_DO"}, 32'(bus.DO), 32'd0);
        checkOutput({tag, "_IOREQ"}, 32'(bus.IOREQ), 32'd0);
        checkOutput({tag, "_IOA"}, 32'(bus.IOA), 32'd0);
        checkOutput({tag, "_IOD"}, 32'(bus.IOD), 32'd0);
        checkOutput({tag, "_IORnW"}, 32'(bus.IORnW), 32'd1);
        checkOutput({tag, "_IODS"}, 32'(bus.IODS), 32'd0);
        checkOutput({tag, "_IOERR"}, 32'(bus.IOERR), 32'd0);
    endtask

    initial begin
        bit ok;
        bit held;
        bus.BACT   = 1'b0;
        bus.IOCS   = 1'b0;
        bus.IOPWCS = 1'b0;
        bus.RnW    = 1'b1;
        bus.A      = '0;
        bus.DI     = '0;
        bus.DS     = '0;

        repeat (3) @(negedge FCLK);
        #1;
        checkResetState("reset");
        @(negedge FCLK);
        nRES = 1'b1;

        // Single posted write, acked after 3 strobes
        $display("[TB] single posted write");
        ackEn    = 1'b1;
        ackDelay = 3;
        applyStimulus(1'b0, 1'b1, 23'h0EFE00, 16'h1234, 2'b11);
        afterEdge();
        checkOutput("pw1_ready", 32'(bus.IOPWReady), 32'd1);
        endCycle();
        afterEdge();
        checkOutput("pw1_readyDrop", 32'(bus.IOPWReady), 32'd0);
        drainBus("pw1_drain", 200);

        // Three back-to-back writes with the ack held off; third stalls on full FIFO
        $display("[TB] FIFO full stall");
        ackEn = 1'b0;
        applyStimulus(1'b0, 1'b1, 23'h000010, 16'hA001, 2'b01);
        afterEdge();
        checkOutput("bb1_ready", 32'(bus.IOPWReady), 32'd1);
        endCycle();
        applyStimulus(1'b0, 1'b1, 23'h000020, 16'hA002, 2'b10);
        afterEdge();
        checkOutput("bb2_ready", 32'(bus.IOPWReady), 32'd1);
        endCycle();
        applyStimulus(1'b0, 1'b1, 23'h000030, 16'hA003, 2'b11);
        repeat (6) afterEdge();
        checkOutput("bb3_stalled", 32'(bus.IOPWReady), 32'd0);
        ackEn    = 1'b1;
        ackDelay = 1;
        waitReady(1'b0, 100, ok);
        checkOutput("bb3_accepted", 32'(ok), 32'd1);
        endCycle();
        drainBus("bb_drain", 300);

        // Posted write followed by a read; the read must follow the write
        $display("[TB] write then read");
        ackDelay = 2;
        rdData   = 16'hBEEF;
        applyStimulus(1'b0, 1'b1, 23'h0EFE00, 16'h5678, 2'b11);
        afterEdge();
        checkOutput("wr_ready", 32'(bus.IOPWReady), 32'd1);
        endCycle();
        applyStimulus(1'b1, 1'b0, 23'h0EFE02, 16'h0000, 2'b11);
        rdQ.push_back(16'hBEEF);
        waitReady(1'b1, 200, ok);
        checkOutput("rd_ready", 32'(ok), 32'd1);
        checkOutput("rd_DO", 32'(bus.DO), 32'(rdQ.pop_front()));
        repeat (3) afterEdge();
        checkOutput("rd_readyHeld", 32'(bus.IONPReady), 32'd1);
        checkOutput("rd_DOHeld", 32'(bus.DO), 32'h0000BEEF);
        endCycle();
        afterEdge();
        checkOutput("rd_readyDrop", 32'(bus.IONPReady), 32'd0);
        drainBus("rd_drain", 100);

        // Read with no acknowledge: watchdog expires
        $display("[TB] timeout read");
        ackEn    = 1'b0;
        errCount = 0;
        rdData   = 16'h1357;
        applyStimulus(1'b1, 1'b0, 23'h000100, 16'h0000, 2'b01);
        rdQ.push_back(16'hFFFF);
        waitReady(1'b1, 800, ok);
        checkOutput("tmo_ready", 32'(ok), 32'd1);
        checkOutput("tmo_DO", 32'(bus.DO), 32'(rdQ.pop_front()));
        checkOutput("tmo_IOREQ", 32'(bus.IOREQ), 32'd0);
        @(negedge FCLK);
        checkOutput("tmo_errPulses", 32'(errCount), 32'd1);
        endCycle();
        ackEn = 1'b1;
        drainBus("tmo_drain", 100);

        // Reset while a slow cycle waits with two writes queued
        $display("[TB] reset during wait");
        ackEn = 1'b0;
        applyStimulus(1'b0, 1'b1, 23'h000200, 16'hC001, 2'b11);
        afterEdge();
        endCycle();
        applyStimulus(1'b0, 1'b1, 23'h000202, 16'hC002, 2'b11);
        void'(expQ.pop_back());
        afterEdge();
        checkOutput("rst_w2Ready", 32'(bus.IOPWReady), 32'd1);
        endCycle();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            afterEdge();
            if (bus.IOREQ === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("rst_reqSeen", 32'(ok), 32'd1);
        @(negedge FCLK);
        nRES = 1'b0;
        #1;
        checkOutput("rst_reqDrop", 32'(bus.IOREQ), 32'd0);
        repeat (2) @(negedge FCLK);
        nRES  = 1'b1;
        ackEn = 1'b1;
        repeat (40) @(negedge FCLK);
        checkResetState("postReset");
        checkOutput("rst_queueEmpty", 32'(expQ.size()), 32'd0);

        // BACT held for 10 FCLKs on one posted write: exactly one push
        $display("[TB] long BACT");
        ackDelay = 2;
        applyStimulus(1'b0, 1'b1, 23'h000300, 16'hD00D, 2'b10);
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            afterEdge();
            if (bus.IOPWReady !== 1'b1) held = 1'b0;
        end
        checkOutput("long_readyHeld", 32'(held), 32'd1);
        endCycle();
        afterEdge();
        checkOutput("long_readyDrop", 32'(bus.IOPWReady), 32'd0);
        drainBus("long_drain", 200);
        repeat (20) @(negedge FCLK);
        checkOutput("final_queueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("final_IOERR", 32'(bus.IOERR), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
